// File: rtl/coin_counter_if.sv
// coin_counter_if
//   Groups the game-side inputs and the counter outputs of coin_counter.
//   master : driver of the game events (game logic / testbench)
//   slave  : the coin_counter itself
//   Signals:
//     game_clear  synchronous clear to reset values (new game)
//     coin_taken  coin collected level; counted once per rising edge
//     life_lost   one-cycle pulse, player died
//     coins_tens  BCD tens digit of coin count
//     coins_ones  BCD ones digit of coin count
//     score_bcd   six BCD digits, [23:20] most significant
//     lives       binary lives count
//     oneup       one-cycle pulse when the coin count wraps 99 -> 00
//     game_over   high while lives == 0
//     busy        high while an update is in progress
interface coin_counter_if;
  logic        game_clear;
  logic        coin_taken;
  logic        life_lost;
  logic [3:0]  coins_tens;
  logic [3:0]  coins_ones;
  logic [23:0] score_bcd;
  logic [3:0]  lives;
  logic        oneup;
  logic        game_over;
  logic        busy;

  modport master (
    output game_clear, coin_taken, life_lost,
    input  coins_tens, coins_ones, score_bcd, lives, oneup, game_over, busy
  );

  modport slave (
    input  game_clear, coin_taken, life_lost,
    output coins_tens, coins_ones, score_bcd, lives, oneup, game_over, busy
  );
endinterface

// File: rtl/coin_counter.sv
// coin_counter
//   Coin / score / lives bookkeeping. Each rising edge of coin_taken is
//   queued in a small pending counter; an FSM services one coin at a time,
//   bumping the BCD coin count and then rippling the score addition one
//   BCD digit per cycle.
//   Ports:
//     Clk    sole clock, all state on its rising edge
//     Reset  asynchronous, active-low reset
//     bus    coin_counter_if.slave (game events in, counters out)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a pending coin
//   COIN   | coin count +1 (BCD), 99->00 wrap gives an extra life
//   SCORE  | add addend to score digit idx, propagate carry one digit/cycle
module coin_counter #(
  parameter logic [3:0] COIN_POINTS = 4'd2,
  parameter logic [3:0] START_LIVES = 4'd3,
  parameter logic [3:0] MAX_LIVES   = 4'd9
) (
  input logic           Clk,
  input logic           Reset,
  coin_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COIN  = 2'd1,
    S_SCORE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_coin_d;
  logic [2:0]  r_pending;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic [23:0] r_score;
  logic [3:0]  r_lives;
  logic        r_oneup;
  logic [2:0]  r_idx;
  logic [3:0]  r_addend;

  logic        w_edge;
  logic        w_leave_idle;
  logic        w_wrap;
  logic [4:0]  w_base;
  logic [3:0]  w_digit;
  logic [4:0]  w_sum;
  logic        w_carry;
  logic [3:0]  w_sum_adj;
  logic        w_last_digit;

  assign w_edge       = bus.coin_taken & ~r_coin_d;
  assign w_leave_idle = (r_state == S_IDLE) && (r_pending != 3'd0);
  assign w_wrap       = (r_state == S_COIN) && (r_tens == 4'd9) && (r_ones == 4'd9);

  assign w_base       = {r_idx, 2'b00};
  assign w_digit      = r_score[w_base +: 4];
  assign w_sum        = {1'b0, w_digit} + {1'b0, r_addend};
  assign w_carry      = (w_sum > 5'd9);
  // sum - 10 modulo 16 is the same as adding 6 in four bits
  assign w_sum_adj    = w_sum[3:0] + 4'd6;
  assign w_last_digit = (r_idx == 3'd5);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_pending != 3'd0) w_state_nxt = S_COIN;
      S_COIN:  w_state_nxt = S_SCORE;
      S_SCORE: if (!w_carry || w_last_digit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else if (bus.game_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_coin_d  <= 1'b0;
      r_pending <= 3'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_score   <= 24'h000000;
      r_lives   <= START_LIVES;
      r_oneup   <= 1'b0;
      r_idx     <= 3'd0;
      r_addend  <= 4'd0;
    end else if (bus.game_clear) begin
      // coin_d follows the input so a level held through the clear is not counted
      r_coin_d  <= bus.coin_taken;
      r_pending <= 3'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_score   <= 24'h000000;
      r_lives   <= START_LIVES;
      r_oneup   <= 1'b0;
      r_idx     <= 3'd0;
      r_addend  <= 4'd0;
    end else begin
      r_coin_d <= bus.coin_taken;

      // simultaneous edge and dequeue cancel; edges beyond 7 are dropped
      if (w_edge && !w_leave_idle && (r_pending != 3'd7)) begin
        r_pending <= r_pending + 3'd1;
      end else if (!w_edge && w_leave_idle) begin
        r_pending <= r_pending - 3'd1;
      end

      if (r_state == S_COIN) begin
        if (r_ones == 4'd9) begin
          r_ones <= 4'd0;
          r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
        r_idx    <= 3'd2;
        r_addend <= COIN_POINTS;
      end

      if (r_state == S_SCORE) begin
        if (w_carry) begin
          if (w_last_digit) begin
            r_score <= 24'h999999;
          end else begin
            r_score[w_base +: 4] <= w_sum_adj;
            r_addend             <= 4'd1;
            r_idx                <= r_idx + 3'd1;
          end
        end else begin
          r_score[w_base +: 4] <= w_sum[3:0];
          r_addend             <= 4'd0;
        end
      end

      r_oneup <= w_wrap;

      // extra life and lost life in the same cycle cancel
      if (w_wrap && !bus.life_lost) begin
        if (r_lives < MAX_LIVES) r_lives <= r_lives + 4'd1;
      end else if (!w_wrap && bus.life_lost) begin
        if (r_lives != 4'd0) r_lives <= r_lives - 4'd1;
      end
    end
  end

  assign bus.coins_tens = r_tens;
  assign bus.coins_ones = r_ones;
  assign bus.score_bcd  = r_score;
  assign bus.lives      = r_lives;
  assign bus.oneup      = r_oneup;
  assign bus.game_over  = (r_lives == 4'd0);
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_coin_counter.sv
// tb_coin_counter
//   Randomised and directed stimulus for coin_counter. A reference model
//   tracks pending coins, service time, coin count, score and lives as plain
//   integers; each serviced coin pushes its expected coins/score into a
//   queue that a monitor pops whenever the DUT drops busy.
module tb_coin_counter;
  localparam int COIN_PTS = 2;
  localparam int START_L  = 3;
  localparam int MAX_L    = 9;
  localparam int SCORE_MAX = 999999;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  coin_counter_if bus();

  coin_counter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic int to_bcd(int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // number of one-digit score cycles needed to add the coin value to s
  function automatic int score_steps(int s);
    int p = 100;
    int idx = 2;
    int steps = 1;
    int d;
    d = (s / p) % 10 + COIN_PTS;
    while (d > 9 && idx < 5) begin
      idx++;
      steps++;
      p = p * 10;
      d = (s / p) % 10 + 1;
    end
    return steps;
  endfunction

  typedef struct {
    int coins;
    int score;
  } exp_t;

  exp_t sbq[$];

  int m_pend, m_svc, m_served, m_score, m_lives;
  bit m_prev, m_coin_edge, m_oneup;

  // reference model
  always @(posedge Clk or negedge Reset) begin : mdl
    bit   e;
    bit   deq;
    bit   wrap;
    int   ns;
    exp_t x;
    if (!Reset) begin
      m_pend <= 0; m_svc <= 0; m_served <= 0; m_score <= 0;
      m_lives <= START_L; m_prev <= 1'b0; m_coin_edge <= 1'b0; m_oneup <= 1'b0;
      sbq.delete();
    end else if (bus.game_clear) begin
      m_pend <= 0; m_svc <= 0; m_served <= 0; m_score <= 0;
      m_lives <= START_L; m_prev <= bus.coin_taken; m_coin_edge <= 1'b0; m_oneup <= 1'b0;
      sbq.delete();
    end else begin
      e   = bus.coin_taken && !m_prev;
      deq = (m_svc == 0) && (m_pend > 0);
      m_prev <= bus.coin_taken;
      if (e && !deq && m_pend < 7) m_pend <= m_pend + 1;
      else if (!e && deq) m_pend <= m_pend - 1;

      if (deq) begin
        ns = m_score + COIN_PTS * 100;
        if (ns > SCORE_MAX) ns = SCORE_MAX;
        m_svc <= 1 + score_steps(m_score);
        m_score <= ns;
        x.coins = (m_served + 1) % 100;
        x.score = ns;
        sbq.push_back(x);
        m_coin_edge <= 1'b1;
      end else if (m_svc > 0) begin
        m_svc <= m_svc - 1;
      end

      wrap = 1'b0;
      if (m_coin_edge) begin
        m_coin_edge <= 1'b0;
        m_served <= m_served + 1;
        wrap = ((m_served + 1) % 100) == 0;
      end
      m_oneup <= wrap;

      if (wrap && !bus.life_lost) begin
        if (m_lives < MAX_L) m_lives <= m_lives + 1;
      end else if (!wrap && bus.life_lost) begin
        if (m_lives > 0) m_lives <= m_lives - 1;
      end
    end
  end

  // monitor / scoreboard
  logic prev_busy = 1'b0;
  always @(negedge Clk) begin : mon
    exp_t x;
    if (Reset) begin
      chk("busy", int'(bus.busy), int'(m_svc > 0));
      chk("lives", int'(bus.lives), m_lives);
      chk("game_over", int'(bus.game_over), int'(m_lives == 0));
      chk("oneup", int'(bus.oneup), int'(m_oneup));
      if (prev_busy && !bus.busy && sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("sb_coins", int'({bus.coins_tens, bus.coins_ones}), to_bcd(x.coins));
        chk("sb_score", int'(bus.score_bcd), to_bcd(x.score));
      end
      prev_busy <= bus.busy;
    end else begin
      prev_busy <= 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || m_pend != 0) && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 1, 0);
    @(negedge Clk);
  endtask

  task automatic coin_one();
    bus.coin_taken = 1'b1;
    @(negedge Clk);
    bus.coin_taken = 1'b0;
    @(negedge Clk);
    wait_idle();
  endtask

  task automatic burst(int edges);
    for (int i = 0; i < edges; i++) begin
      bus.coin_taken = 1'b1;
      @(negedge Clk);
      bus.coin_taken = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    int n;
    bus.game_clear = 1'b0;
    bus.coin_taken = 1'b0;
    bus.life_lost  = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_coins", int'({bus.coins_tens, bus.coins_ones}), 0);
    chk("rst_score", int'(bus.score_bcd), 0);
    chk("rst_lives", int'(bus.lives), START_L);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_oneup", int'(bus.oneup), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // single coin latency from reset
    bus.coin_taken = 1'b1;
    @(negedge Clk);                       // after edge k
    bus.coin_taken = 1'b0;
    chk("lat_busy_k", int'(bus.busy), 0);
    @(negedge Clk);                       // after k+1
    chk("lat_busy_k1", int'(bus.busy), 1);
    chk("lat_coins_k1", int'({bus.coins_tens, bus.coins_ones}), 0);
    @(negedge Clk);                       // after k+2
    chk("lat_coins_k2", int'({bus.coins_tens, bus.coins_ones}), 'h01);
    chk("lat_busy_k2", int'(bus.busy), 1);
    chk("lat_score_k2", int'(bus.score_bcd), 0);
    @(negedge Clk);                       // after k+3
    chk("lat_score_k3", int'(bus.score_bcd), 'h000200);
    chk("lat_busy_k3", int'(bus.busy), 0);

    // lives decrement and floor
    for (int i = 0; i < 4; i++) begin
      bus.life_lost = 1'b1;
      @(negedge Clk);
      bus.life_lost = 1'b0;
      chk("life_dec", int'(bus.lives), (i < 3) ? 2 - i : 0);
      chk("life_go", int'(bus.game_over), (i >= 2) ? 1 : 0);
    end

    // new game
    bus.game_clear = 1'b1;
    @(negedge Clk);
    bus.game_clear = 1'b0;
    chk("clr_lives", int'(bus.lives), START_L);
    chk("clr_score", int'(bus.score_bcd), 0);

    // 99 coins, then the wrap coin with a coincident life_lost
    for (int i = 0; i < 99; i++) coin_one();
    chk("pre99_coins", int'({bus.coins_tens, bus.coins_ones}), 'h99);
    chk("pre99_score", int'(bus.score_bcd), 'h019800);
    bus.coin_taken = 1'b1;
    @(negedge Clk);                       // after k
    bus.coin_taken = 1'b0;
    @(negedge Clk);                       // after k+1
    bus.life_lost = 1'b1;                 // sampled at the COIN edge
    @(negedge Clk);
    bus.life_lost = 1'b0;
    chk("wrap_oneup", int'(bus.oneup), 1);
    chk("wrap_coins", int'({bus.coins_tens, bus.coins_ones}), 0);
    chk("wrap_lives_cancel", int'(bus.lives), START_L);
    @(negedge Clk);
    chk("wrap_oneup_pulse", int'(bus.oneup), 0);
    wait_idle();
    for (int i = 0; i < 100; i++) coin_one();
    chk("wrap2_lives", int'(bus.lives), START_L + 1);

    // rapid edges: pending saturation
    burst(10);
    wait_idle();
    chk("burst_coins", int'({bus.coins_tens, bus.coins_ones}), to_bcd(m_served % 100));

    // game_clear mid-update with coins pending
    bus.life_lost = 1'b1;
    @(negedge Clk);
    bus.life_lost = 1'b0;
    burst(6);
    @(negedge Clk);
    bus.game_clear = 1'b1;
    @(negedge Clk);
    bus.game_clear = 1'b0;
    chk("gc_coins", int'({bus.coins_tens, bus.coins_ones}), 0);
    chk("gc_score", int'(bus.score_bcd), 0);
    chk("gc_lives", int'(bus.lives), START_L);
    chk("gc_busy", int'(bus.busy), 0);
    repeat (3) @(negedge Clk);
    chk("gc_stays_idle", int'(bus.busy), 0);

    // asynchronous reset mid-update
    bus.life_lost = 1'b1;
    @(negedge Clk);
    bus.life_lost = 1'b0;
    burst(4);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("ar_coins", int'({bus.coins_tens, bus.coins_ones}), 0);
    chk("ar_score", int'(bus.score_bcd), 0);
    chk("ar_lives", int'(bus.lives), START_L);
    chk("ar_busy", int'(bus.busy), 0);
    chk("ar_oneup", int'(bus.oneup), 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("ar_no_resume", int'(bus.busy), 0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      bus.coin_taken = 1'($urandom_range(0, 1));
      bus.life_lost  = ($urandom_range(0, 15) == 0);
      bus.game_clear = ($urandom_range(0, 499) == 0);
      @(negedge Clk);
    end
    bus.coin_taken = 1'b0;
    bus.life_lost  = 1'b0;
    bus.game_clear = 1'b0;
    wait_idle();

    // long run to score saturation
    bus.game_clear = 1'b1;
    @(negedge Clk);
    bus.game_clear = 1'b0;
    n = 0;
    while (m_served < 5005 && n < 40000) begin
      bus.coin_taken = ~bus.coin_taken;
      bus.life_lost  = ($urandom_range(0, 63) == 0);
      @(negedge Clk);
      n++;
    end
    if (n >= 40000) chk("sat_timeout", 1, 0);
    bus.coin_taken = 1'b0;
    bus.life_lost  = 1'b0;
    wait_idle();
    chk("sat_score", int'(bus.score_bcd), 'h999999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
